// File: rtl/pt2262_frame_encoder.sv
// PT2262-style tri-state remote-control frame encoder.
// Emits CODE_TRITS code trits (32 alpha each) followed by a 128-alpha sync, repeating at least MIN_FRAMES times.
//
// state  | meaning
// -------+--------------------------------------------------
// S_IDLE | waiting for TX_EN on an alpha tick, DOUT low
// S_CODE | emitting code trit idx_q, alpha slot alpha_q (0..31)
// S_SYNC | emitting sync, alpha slot alpha_q (0..127)
module pt2262_frame_encoder #(
   parameter int CODE_TRITS = 12,
   parameter int MIN_FRAMES = 4
) (
   input  logic                    INPUT_CLK,
   input  logic                    RST,
   input  logic                    OSC_CLK_IN,
   input  logic                    TX_EN,
   input  logic [2*CODE_TRITS-1:0] CODE,
   output logic                    DOUT,
   output logic                    BUSY,
   output logic                    FRAME_DONE
);

   localparam int IW = (CODE_TRITS > 1) ? $clog2(CODE_TRITS) : 1;
   localparam int FW = $clog2(MIN_FRAMES + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(CODE_TRITS - 1);
   localparam logic [FW-1:0] FRM_SAT  = FW'(MIN_FRAMES);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CODE = 2'd1;
   localparam logic [1:0] S_SYNC = 2'd2;

   logic                    osc_dly_q;
   logic                    tick;
   logic [1:0]              state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [6:0]              alpha_q, alpha_d;
   logic [FW-1:0]           frm_q, frm_d;
   logic [2*CODE_TRITS-1:0] shadow_q, shadow_d;
   logic                    dout_q, dout_d;
   logic                    busy_q;
   logic                    done_q, done_d;
   logic [1:0]              trit;

   assign tick = OSC_CLK_IN & ~osc_dly_q;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      alpha_d  = alpha_q;
      frm_d    = frm_q;
      shadow_d = shadow_q;
      done_d   = 1'b0;
      if (tick) begin
         case (state_q)
            S_IDLE: begin
               if (TX_EN) begin
                  shadow_d = CODE;
                  frm_d    = '0;
                  idx_d    = '0;
                  alpha_d  = '0;
                  state_d  = S_CODE;
               end
            end
            S_CODE: begin
               if (alpha_q == 7'd31) begin
                  alpha_d = '0;
                  if (idx_q == LAST_IDX) state_d = S_SYNC;
                  else                   idx_d   = idx_q + 1'b1;
               end else begin
                  alpha_d = alpha_q + 7'd1;
               end
            end
            S_SYNC: begin
               if (alpha_q == 7'd127) begin
                  done_d  = 1'b1;
                  alpha_d = '0;
                  idx_d   = '0;
                  if (frm_q != FRM_SAT) frm_d = frm_q + 1'b1;
                  // back-to-back restart: next frame begins on this same tick
                  if (TX_EN || (frm_d < FRM_SAT)) begin
                     shadow_d = CODE;
                     state_d  = S_CODE;
                  end else begin
                     state_d  = S_IDLE;
                  end
               end else begin
                  alpha_d = alpha_q + 7'd1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign trit = shadow_d[{idx_d, 1'b0} +: 2];

   // DOUT reflects the slot held after this edge, so the first high appears on the entering tick
   always_comb begin
      dout_d = 1'b0;
      case (state_d)
         S_CODE: begin
            case (trit)
               2'b00:   dout_d = (alpha_d < 7'd4)  || ((alpha_d >= 7'd16) && (alpha_d < 7'd20));
               2'b11:   dout_d = (alpha_d < 7'd12) || ((alpha_d >= 7'd16) && (alpha_d < 7'd28));
               default: dout_d = (alpha_d < 7'd4)  || ((alpha_d >= 7'd16) && (alpha_d < 7'd28));
            endcase
         end
         S_SYNC:  dout_d = (alpha_d < 7'd4);
         default: dout_d = 1'b0;
      endcase
   end

   always_ff @(posedge INPUT_CLK or negedge RST) begin
      if (!RST) begin
         osc_dly_q <= 1'b1;
         state_q   <= S_IDLE;
         idx_q     <= '0;
         alpha_q   <= '0;
         frm_q     <= '0;
         shadow_q  <= '0;
         dout_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         osc_dly_q <= OSC_CLK_IN;
         state_q   <= state_d;
         idx_q     <= idx_d;
         alpha_q   <= alpha_d;
         frm_q     <= frm_d;
         shadow_q  <= shadow_d;
         dout_q    <= dout_d;
         busy_q    <= (state_d != S_IDLE);
         done_q    <= done_d;
      end
   end

   assign DOUT       = dout_q;
   assign BUSY       = busy_q;
   assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_pt2262_frame_encoder.sv
// Scoreboard bench for pt2262_frame_encoder: stimulus queues expected frames, a monitor
// captures DOUT on every alpha tick and checks each completed frame.
module tb_pt2262_frame_encoder;

   localparam int FL = 512;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        osc    = 1'b0;
   logic        tx_en  = 1'b0;
   logic [23:0] code   = 24'h0;
   logic        dout, busy, fdone;

   typedef struct {
      logic [23:0] code;
      int          high;
   } exp_t;

   exp_t sb[$];
   int   total    = 0;
   int   bad      = 0;
   int   done_cnt = 0;
   bit   freeze   = 1'b0;
   int   div      = 0;

   logic osc_prev_m, tick_r;
   wire  tick_m = osc & ~osc_prev_m;

   always #5 clk = ~clk;

   pt2262_frame_encoder #(.CODE_TRITS(12), .MIN_FRAMES(4)) dut (
      .INPUT_CLK  (clk),
      .RST        (rst_n),
      .OSC_CLK_IN (osc),
      .TX_EN      (tx_en),
      .CODE       (code),
      .DOUT       (dout),
      .BUSY       (busy),
      .FRAME_DONE (fdone)
   );

   // alpha period of 4 clocks: osc is 2 clocks high, 2 low, changed on falling edges
   initial begin
      forever begin
         @(negedge clk);
         if (freeze) osc = 1'b1;
         else begin
            div = div + 1;
            osc = div[1];
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         osc_prev_m <= 1'b1;
         tick_r     <= 1'b0;
      end else begin
         osc_prev_m <= osc;
         tick_r     <= tick_m;
      end
   end

   task automatic check(input string nm, input logic [511:0] got, input logic [511:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", nm, got, want);
      end
   endtask

   function automatic logic [511:0] model_wave(input logic [23:0] c);
      logic [511:0] w;
      logic [1:0]   tr;
      int           t, a;
      w = '0;
      for (int s = 0; s < FL; s++) begin
         if (s < 384) begin
            t  = s / 32;
            a  = s % 32;
            tr = c[2*t +: 2];
            case (tr)
               2'b00:   w[s] = (a < 4)  || (a >= 16 && a < 20);
               2'b11:   w[s] = (a < 12) || (a >= 16 && a < 28);
               default: w[s] = (a < 4)  || (a >= 16 && a < 28);
            endcase
         end else begin
            w[s] = (s - 384) < 4;
         end
      end
      return w;
   endfunction

   // monitor: one DOUT sample per tick while busy; FRAME_DONE closes the frame being collected
   initial begin
      logic [511:0] got;
      int           cur_n;
      exp_t         e;
      got   = '0;
      cur_n = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            got   = '0;
            cur_n = 0;
         end else if (tick_r) begin
            if (fdone) begin
               done_cnt++;
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_frame: got=frame_done want=none");
               end else begin
                  e = sb.pop_front();
                  check("frame_len",  512'(cur_n), 512'(FL));
                  check("frame_high", 512'($countones(got)), 512'(e.high));
                  check("frame_wave", got, model_wave(e.code));
               end
               got   = '0;
               cur_n = 0;
            end
            if (busy) begin
               if (cur_n < FL) got[cur_n] = dout;
               cur_n++;
            end
         end
      end
   end

   task automatic wait_ticks(input int n);
      int cyc;
      for (int i = 0; i < n; i++) begin
         cyc = 0;
         do begin
            @(posedge clk);
            #1;
            cyc++;
         end while (!tick_r && cyc < 200);
         if (!tick_r) begin
            total++;
            bad++;
            $display("FAIL tick_timeout: got=no_tick want=tick");
            return;
         end
      end
   endtask

   task automatic wait_idle(input int budget);
      int cyc;
      cyc = 0;
      while (busy && cyc < budget) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (busy) begin
         total++;
         bad++;
         $display("FAIL idle_timeout: got=busy want=idle");
      end
   endtask

   task automatic wait_done(input int target, input int budget);
      int cyc;
      cyc = 0;
      while (done_cnt < target && cyc < budget) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (done_cnt < target) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got=%0d want=%0d", done_cnt, target);
      end
   endtask

   task automatic request(input logic [23:0] c, input int high, input bit push);
      if (push) repeat (4) sb.push_back('{code: c, high: high});
      code  = c;
      tx_en = 1'b1;
      wait_ticks(1);
      tx_en = 1'b0;
   endtask

   initial begin
      int base;
      int frz_bad;

      repeat (3) @(negedge clk);
      check("rst_dout", 512'(dout), 512'(0));
      check("rst_busy", 512'(busy), 512'(0));
      check("rst_done", 512'(fdone), 512'(0));
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // all '0': 12*8 + 4 high alpha per frame
      base = done_cnt;
      request(24'h000000, 100, 1'b1);
      wait_idle(10000);
      check("s1_frames", 512'(done_cnt - base), 512'(4));
      check("s1_dout_idle", 512'(dout), 512'(0));

      // all '1': 12*24 + 4
      base = done_cnt;
      request(24'hFFFFFF, 292, 1'b1);
      wait_idle(10000);
      check("s2_frames", 512'(done_cnt - base), 512'(4));
      check("s2_busy", 512'(busy), 512'(0));

      // trits 00,11,01,10 then eight '0': 8+24+16+16+64+4
      base = done_cnt;
      request(24'h00009C, 132, 1'b1);
      wait_idle(10000);
      check("s3_frames", 512'(done_cnt - base), 512'(4));

      // TX_EN high for one clock between ticks is never seen
      wait_ticks(1);
      tx_en = 1'b1;
      @(posedge clk);
      #1;
      tx_en = 1'b0;
      wait_ticks(3);
      check("short_pulse_busy", 512'(busy), 512'(0));

      // TX_EN held for 10 frames, CODE changed inside frame 3
      base = done_cnt;
      repeat (3) sb.push_back('{code: 24'hFFFFFF, high: 292});
      repeat (7) sb.push_back('{code: 24'h00009C, high: 132});
      code  = 24'hFFFFFF;
      tx_en = 1'b1;
      wait_ticks(1);
      wait_done(base + 2, 6000);
      wait_ticks(200);
      code = 24'h00009C;
      wait_done(base + 9, 20000);
      wait_ticks(50);
      tx_en = 1'b0;
      wait_idle(3000);
      check("s4_frames", 512'(done_cnt - base), 512'(10));

      // reset at trit 5, a = 10 (slot 170, high for a '1' trit)
      base = done_cnt;
      request(24'hFFFFFF, 292, 1'b0);
      wait_ticks(170);
      check("s5_pre_dout", 512'(dout), 512'(1));
      check("s5_pre_busy", 512'(busy), 512'(1));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("s5_rst_dout", 512'(dout), 512'(0));
      check("s5_rst_busy", 512'(busy), 512'(0));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("s5_no_done", 512'(done_cnt - base), 512'(0));
      base = done_cnt;
      request(24'hFFFFFF, 292, 1'b1);
      wait_idle(10000);
      check("s5_frames", 512'(done_cnt - base), 512'(4));

      // osc frozen high for 100 clocks at slot 97 (trit 3, a = 1 of an all-'0' code)
      base = done_cnt;
      request(24'h000000, 100, 1'b1);
      wait_ticks(97);
      check("s6_pre_dout", 512'(dout), 512'(1));
      freeze  = 1'b1;
      frz_bad = 0;
      repeat (100) begin
         @(posedge clk);
         #1;
         if (dout !== 1'b1 || busy !== 1'b1 || fdone !== 1'b0) frz_bad++;
      end
      check("s6_frozen", 512'(frz_bad), 512'(0));
      freeze = 1'b0;
      wait_idle(10000);
      check("s6_frames", 512'(done_cnt - base), 512'(4));

      check("sb_empty", 512'(sb.size()), 512'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
